// File: rtl/quad_thread_sched.sv
// quad_thread_sched: round-robin fetch scheduler for four hardware threads.
// Optional macro SCHED_PERF_CNT_EN adds per-thread grant counters and an idle-cycle counter.
module quad_thread_sched #(
    parameter int PC_W        = 32,
    parameter int PC_INC      = 4,
    parameter int REISSUE_GAP = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [3:0]      thread_en_i,
    input  logic [PC_W-1:0] boot_pc_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [1:0]      redirect_tid_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            halt_valid_i,
    input  logic [1:0]      halt_tid_i,
    output logic            fetch_valid_o,
    output logic [1:0]      fetch_tid_o,
    output logic [PC_W-1:0] fetch_pc_o,
    output logic [3:0]      thread_active_o,
`ifdef SCHED_PERF_CNT_EN
    output logic [127:0]    issue_cnt_o,
    output logic [31:0]     idle_cnt_o,
`endif
    output logic            all_halted_o
);
    typedef enum logic [1:0] {OFF, RUN, WAIT, HALT} state_t;

    state_t          r_state [4];
    state_t          w_state [4];
    logic [PC_W-1:0] r_pc    [4];
    logic [PC_W-1:0] w_pc    [4];
    logic [1:0]      r_cnt   [4];
    logic [1:0]      w_cnt   [4];
    logic [1:0]      r_rr;
    logic [1:0]      w_win;
    logic            w_gnt;
    logic            w_busy;
    logic            w_start;
    logic [3:0]      w_live;
    logic [3:0]      w_redir;
    logic [3:0]      w_halt;
    logic [3:0]      w_elig;
    logic [3:0]      w_act;

    assign w_busy  = |w_live;
    assign w_start = start_i && !stall_i && !w_busy;

    // Classify each thread: live, hit by redirect/halt, and eligible to fetch now.
    always_comb begin
        for (int t = 0; t < 4; t++) begin
            w_live[t]  = r_state[t] == RUN || r_state[t] == WAIT;
            w_redir[t] = redirect_valid_i && redirect_tid_i == 2'(t) && w_live[t];
            w_halt[t]  = halt_valid_i && halt_tid_i == 2'(t) && w_live[t];
            w_elig[t]  = r_state[t] == RUN && !w_redir[t] && !w_halt[t] && !stall_i;
        end
    end

    // First eligible thread at or after the round-robin pointer wins.
    always_comb begin
        w_gnt = 1'b0;
        w_win = r_rr;
        for (int i = 0; i < 4; i++)
            if (!w_gnt && w_elig[r_rr + 2'(i)]) begin
                w_gnt = 1'b1;
                w_win = r_rr + 2'(i);
            end
    end

    // Per-thread next state; halt beats redirect, which beats start/issue/gap countdown.
    always_comb begin
        for (int t = 0; t < 4; t++) begin
            w_state[t] = r_state[t];
            w_pc[t]    = r_pc[t];
            w_cnt[t]   = r_cnt[t];
            if (w_halt[t]) begin
                w_state[t] = HALT;
                w_cnt[t]   = 2'd0;
            end else if (w_redir[t]) begin
                w_state[t] = RUN;
                w_pc[t]    = redirect_pc_i;
                w_cnt[t]   = 2'd0;
            end else if (!stall_i) begin
                if (w_start && thread_en_i[t]) begin
                    w_state[t] = RUN;
                    w_pc[t]    = boot_pc_i;
                    w_cnt[t]   = 2'd0;
                end else if (w_gnt && w_win == 2'(t)) begin
                    w_pc[t]    = r_pc[t] + PC_W'(PC_INC);
                    w_state[t] = REISSUE_GAP > 0 ? WAIT : RUN;
                    w_cnt[t]   = 2'(REISSUE_GAP);
                end else if (r_state[t] == WAIT) begin
                    w_state[t] = r_cnt[t] <= 2'd1 ? RUN : WAIT;
                    w_cnt[t]   = r_cnt[t] <= 2'd1 ? 2'd0 : r_cnt[t] - 2'd1;
                end
            end
            w_act[t] = w_state[t] == RUN || w_state[t] == WAIT;
        end
    end

    // Thread state, PCs, pointer and registered fetch/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 4; t++) begin
                r_state[t] <= OFF;
                r_pc[t]    <= '0;
                r_cnt[t]   <= 2'd0;
            end
            r_rr            <= 2'd0;
            fetch_valid_o   <= 1'b0;
            fetch_tid_o     <= 2'd0;
            fetch_pc_o      <= '0;
            thread_active_o <= 4'd0;
            all_halted_o    <= 1'b1;
        end else begin
            for (int t = 0; t < 4; t++) begin
                r_state[t] <= w_state[t];
                r_pc[t]    <= w_pc[t];
                r_cnt[t]   <= w_cnt[t];
            end
            thread_active_o <= w_act;
            all_halted_o    <= ~|w_act;
            if (!stall_i)
                fetch_valid_o <= w_gnt;
            if (w_gnt) begin
                fetch_tid_o <= w_win;
                fetch_pc_o  <= r_pc[w_win];
                r_rr        <= w_win + 2'd1;
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [3:0][31:0] r_issue;
    logic [31:0]      r_idle;

    assign issue_cnt_o = r_issue;
    assign idle_cnt_o  = r_idle;

    // Saturating grant and idle counters, restarted with each accepted launch.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_issue <= '0;
            r_idle  <= '0;
        end else begin
            for (int t = 0; t < 4; t++)
                if (w_gnt && w_win == 2'(t) && r_issue[t] != '1)
                    r_issue[t] <= r_issue[t] + 32'd1;
            if (!stall_i && !fetch_valid_o && r_idle != '1)
                r_idle <= r_idle + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_quad_thread_sched.sv
// tb_quad_thread_sched: two schedulers (gap 0 and gap 1) on shared stimulus, checked against a rule-level model.
module tb_quad_thread_sched;
    logic        clk = 0;
    logic        rst = 0;
    logic        start = 0;
    logic [3:0]  en = 0;
    logic [31:0] boot = 0;
    logic        stall = 0;
    logic        rv = 0;
    logic [1:0]  rtid = 0;
    logic [31:0] rpc = 0;
    logic        hv = 0;
    logic [1:0]  htid = 0;

    logic        fv  [2];
    logic [1:0]  ft  [2];
    logic [31:0] fp  [2];
    logic [3:0]  act [2];
    logic        ah  [2];

    int checks = 0;
    int failures = 0;

    // reference model: thread modes 0=off 1=run 2=wait 3=halt
    int          m_st  [2][4];
    logic [31:0] m_pc  [2][4];
    int          m_wt  [2][4];
    int          m_rr  [2];
    logic        ev    [2];
    logic [1:0]  et    [2];
    logic [31:0] ep    [2];
    logic [3:0]  eact  [2];
    logic        eall  [2];

    always #5 clk = ~clk;

    quad_thread_sched #(.PC_W(32), .PC_INC(4), .REISSUE_GAP(0)) u0 (
        .clk(clk), .rst(rst), .start_i(start), .thread_en_i(en), .boot_pc_i(boot),
        .stall_i(stall), .redirect_valid_i(rv), .redirect_tid_i(rtid), .redirect_pc_i(rpc),
        .halt_valid_i(hv), .halt_tid_i(htid), .fetch_valid_o(fv[0]), .fetch_tid_o(ft[0]),
        .fetch_pc_o(fp[0]), .thread_active_o(act[0]), .all_halted_o(ah[0]));

    quad_thread_sched #(.PC_W(32), .PC_INC(4), .REISSUE_GAP(1)) u1 (
        .clk(clk), .rst(rst), .start_i(start), .thread_en_i(en), .boot_pc_i(boot),
        .stall_i(stall), .redirect_valid_i(rv), .redirect_tid_i(rtid), .redirect_pc_i(rpc),
        .halt_valid_i(hv), .halt_tid_i(htid), .fetch_valid_o(fv[1]), .fetch_tid_o(ft[1]),
        .fetch_pc_o(fp[1]), .thread_active_o(act[1]), .all_halted_o(ah[1]));

    // Apply one clock edge of the scheduling rules to the model (instance g has gap g).
    task automatic model_step();
        for (int g = 0; g < 2; g++) begin
            int win;
            bit busy;
            if (rst) begin
                for (int t = 0; t < 4; t++) begin
                    m_st[g][t] = 0; m_pc[g][t] = 0; m_wt[g][t] = 0;
                end
                m_rr[g] = 0; ev[g] = 0; et[g] = 0; ep[g] = 0; eact[g] = 0; eall[g] = 1;
                continue;
            end
            busy = 0;
            for (int t = 0; t < 4; t++) busy |= (m_st[g][t] == 1 || m_st[g][t] == 2);
            win = -1;
            if (!stall)
                for (int k = 0; k < 4; k++) begin
                    int t = (m_rr[g] + k) % 4;
                    if (win < 0 && m_st[g][t] == 1 && !(rv && rtid == t) && !(hv && htid == t)) win = t;
                end
            for (int t = 0; t < 4; t++) begin
                bit live = (m_st[g][t] == 1 || m_st[g][t] == 2);
                if (hv && htid == t && live) m_st[g][t] = 3;
                else if (rv && rtid == t && live) begin
                    m_st[g][t] = 1; m_pc[g][t] = rpc; m_wt[g][t] = 0;
                end else if (!stall) begin
                    if (start && !busy && en[t]) begin
                        m_st[g][t] = 1; m_pc[g][t] = boot; m_wt[g][t] = 0;
                    end else if (t == win) begin
                        ep[g] = m_pc[g][t];
                        m_pc[g][t] = m_pc[g][t] + 4;
                        if (g > 0) begin m_st[g][t] = 2; m_wt[g][t] = g; end
                    end else if (m_st[g][t] == 2) begin
                        m_wt[g][t]--;
                        if (m_wt[g][t] == 0) m_st[g][t] = 1;
                    end
                end
            end
            if (!stall) begin
                ev[g] = win >= 0;
                if (win >= 0) begin et[g] = 2'(win); m_rr[g] = (win + 1) % 4; end
            end
            for (int t = 0; t < 4; t++) eact[g][t] = (m_st[g][t] == 1 || m_st[g][t] == 2);
            eall[g] = eact[g] == 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        {start, en, boot, stall, rv, rtid, rpc, hv, htid} = '0;
        rst = 1; tick(); rst = 0;
    endtask

    task automatic launch(input logic [3:0] e, input logic [31:0] b);
        start = 1; en = e; boot = b; tick(); start = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({fv[g], ft[g], fp[g], act[g], ah[g]} !== {1'b0, 2'd0, 32'd0, 4'd0, 1'b1}) begin
                failures++;
                $display("FAIL reset g%0d: got v=%0b t=%0d pc=%h act=%b ah=%0b, need 0 0 0 0 1", g, fv[g], ft[g], fp[g], act[g], ah[g]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        launch(4'b1111, 32'h100);
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int g = 0; g < 2; g++) begin
                checks++;
                if ({fv[g], ft[g], fp[g]} !== {1'b1, 2'(i % 4), 32'h100 + 32'(4 * (i / 4))}) begin
                    failures++;
                    $display("FAIL rr g%0d step%0d: got v=%0b t=%0d pc=%h, need 1 %0d %h", g, i, fv[g], ft[g], fp[g], i % 4, 32'h100 + 4 * (i / 4));
                end
            end
        end
    endtask

    task automatic test_sparse_gap();
        do_reset();
        launch(4'b0101, 32'h100);
        for (int i = 0; i < 4; i++) begin
            tick();
            for (int g = 0; g < 2; g++) begin
                checks++;
                if ({fv[g], ft[g]} !== {1'b1, 2'((i % 2) * 2)}) begin
                    failures++;
                    $display("FAIL sparse g%0d step%0d: got v=%0b t=%0d, need 1 %0d", g, i, fv[g], ft[g], (i % 2) * 2);
                end
            end
        end
        do_reset();
        launch(4'b0001, 32'h100);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({fv[1], fp[1]} !== {1'(i % 2 == 0), 32'h100 + 32'(4 * (i / 2))}) begin
                failures++;
                $display("FAIL single_gap step%0d: got v=%0b pc=%h, need %0d %h", i, fv[1], fp[1], i % 2 == 0, 32'h100 + 4 * (i / 2));
            end
        end
    endtask

    task automatic test_redirect();
        int n [2];
        n = '{0, 0};
        do_reset();
        launch(4'b1111, 32'h100);
        tick(); tick();
        rv = 1; rtid = 2; rpc = 32'h400;
        tick();
        rv = 0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({fv[g], ft[g]} !== {1'b1, 2'd3}) begin
                failures++;
                $display("FAIL redirect_skip g%0d: got v=%0b t=%0d, need 1 3", g, fv[g], ft[g]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int g = 0; g < 2; g++)
                if (fv[g] && ft[g] == 2) begin
                    checks++;
                    if (fp[g] !== 32'h400 + 32'(4 * n[g])) begin
                        failures++;
                        $display("FAIL redirect_pc g%0d #%0d: got %h need %h", g, n[g], fp[g], 32'h400 + 4 * n[g]);
                    end
                    n[g]++;
                end
        end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (n[g] < 2) begin
                failures++;
                $display("FAIL redirect_count g%0d: got %0d thread-2 fetches, need >=2", g, n[g]);
            end
        end
    endtask

    task automatic test_halt();
        int hs [3] = '{0, 2, 3};
        do_reset();
        launch(4'b1111, 32'h100);
        tick();
        hv = 1; htid = 1; rv = 1; rtid = 1; rpc = 32'h800;
        tick();
        hv = 0; rv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int g = 0; g < 2; g++) begin
                checks++;
                if ((fv[g] && ft[g] == 2'd1) || act[g][1] !== 1'b0) begin
                    failures++;
                    $display("FAIL halted_fetch g%0d: got v=%0b t=%0d act=%b, need thread 1 idle", g, fv[g], ft[g], act[g]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            hv = 1; htid = 2'(hs[i]);
            tick();
        end
        hv = 0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({fv[g], act[g], ah[g]} !== {1'b0, 4'd0, 1'b1}) begin
                failures++;
                $display("FAIL all_halted g%0d: got v=%0b act=%b ah=%0b, need 0 0000 1", g, fv[g], act[g], ah[g]);
            end
        end
    endtask

    task automatic test_stall();
        logic [1:0]  t0;
        logic [31:0] p0;
        do_reset();
        launch(4'b1111, 32'h100);
        for (int i = 0; i < 6; i++) tick();
        t0 = ft[0]; p0 = fp[0];
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({fv[0], ft[0], fp[0]} !== {1'b1, t0, p0}) begin
                failures++;
                $display("FAIL stall_hold c%0d: got v=%0b t=%0d pc=%h, need 1 %0d %h", i, fv[0], ft[0], fp[0], t0, p0);
            end
        end
        stall = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int g = 0; g < 2; g++) begin
                checks++;
                if ({fv[g], ft[g], fp[g]} !== {ev[g], et[g], ep[g]}) begin
                    failures++;
                    $display("FAIL stall_resume g%0d c%0d: got v=%0b t=%0d pc=%h, need %0b %0d %h", g, i, fv[g], ft[g], fp[g], ev[g], et[g], ep[g]);
                end
            end
            if (i == 0) begin
                checks++;
                if (ft[0] !== t0 + 2'd1) begin
                    failures++;
                    $display("FAIL stall_next_tid: got %0d need %0d", ft[0], t0 + 2'd1);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        launch(4'b1111, 32'h100);
        for (int i = 0; i < 5; i++) tick();
        rst = 1; tick(); rst = 0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({fv[g], ft[g], fp[g], act[g], ah[g]} !== {1'b0, 2'd0, 32'd0, 4'd0, 1'b1}) begin
                failures++;
                $display("FAIL midrun_reset g%0d: got v=%0b t=%0d pc=%h act=%b ah=%0b", g, fv[g], ft[g], fp[g], act[g], ah[g]);
            end
        end
        launch(4'b1111, 32'h200);
        tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({fv[g], ft[g], fp[g], ah[g]} !== {1'b1, 2'd0, 32'h200, 1'b0}) begin
                failures++;
                $display("FAIL restart g%0d: got v=%0b t=%0d pc=%h ah=%0b, need 1 0 200 0", g, fv[g], ft[g], fp[g], ah[g]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        launch(4'($urandom_range(15, 1)), {$urandom} & 32'hFFFF_FFFC);
        for (int i = 0; i < 600; i++) begin
            stall = $urandom % 5 == 0;
            rv    = $urandom % 6 == 0;
            rtid  = 2'($urandom);
            rpc   = $urandom;
            hv    = $urandom % 14 == 0;
            htid  = 2'($urandom);
            start = $urandom % 8 == 0;
            en    = 4'($urandom);
            boot  = $urandom;
            tick();
            for (int g = 0; g < 2; g++) begin
                checks++;
                if ({fv[g], ft[g], fp[g], act[g], ah[g]} !== {ev[g], et[g], ep[g], eact[g], eall[g]}) begin
                    failures++;
                    $display("FAIL random g%0d c%0d: got v=%0b t=%0d pc=%h act=%b ah=%0b, need %0b %0d %h %b %0b",
                             g, i, fv[g], ft[g], fp[g], act[g], ah[g], ev[g], et[g], ep[g], eact[g], eall[g]);
                end
            end
        end
        {start, stall, rv, hv} = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse_gap();
        test_redirect();
        test_halt();
        test_stall();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/quad_thread_sched.md
Name: quad_thread_sched

Overview:
- Fine-grained thread scheduler for the quad-threaded 5-stage ARM pipeline.
- Owns the four per-thread PCs and picks one thread per cycle to fetch, using round-robin over eligible threads.
- Accepts branch redirects and halt notifications from the pipeline.
- Drives the instruction-memory address and the thread ID that travels down the pipe.

Parameters:
- PC_W, 32, PC width (matches PC_WIDTH define).
- PC_INC, 4, byte increment applied to a thread's PC on each fetch.
- REISSUE_GAP, 0, minimum idle cycles after a thread issues before it is eligible again. Range 0..3; 3 gives strict barrel spacing.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle pulse; launches threads selected by thread_en_i
- thread_en_i  in  4  per-thread enable, sampled on start_i
- boot_pc_i  in  PC_W  initial PC loaded into every enabled thread on start_i
- stall_i  in  1  pipeline stall; freezes scheduler
- redirect_valid_i  in  1  branch/exception redirect
- redirect_tid_i  in  2  thread being redirected
- redirect_pc_i  in  PC_W  new PC
- halt_valid_i  in  1  thread has retired a halt
- halt_tid_i  in  2  halting thread
- fetch_valid_o  out  1  fetch slot valid this cycle
- fetch_tid_o  out  2  thread ID of fetch slot
- fetch_pc_o  out  PC_W  PC to instruction memory (drives i_mem_addr)
- thread_active_o  out  4  thread state RUN or WAIT
- all_halted_o  out  1  no thread in RUN/WAIT since last start

Behaviour:
Reset (rst=1 at posedge):
- All threads OFF, PCs 0, RR pointer 0, gap counters 0.
- fetch_valid_o=0, fetch_tid_o=0, fetch_pc_o=0, thread_active_o=0, all_halted_o=1.
- Reset mid-run discards all state identically.

Per-thread FSM (states OFF, RUN, WAIT, HALT):
- OFF/HALT -> RUN on start_i with thread_en_i[t]=1; pc[t]<=boot_pc_i.
- start_i while any thread RUN/WAIT: ignored.
- RUN -> WAIT when thread issues and REISSUE_GAP>0; the gap counter loads REISSUE_GAP.
- WAIT -> RUN when the counter reaches 0. The counter decrements only when stall_i=0.
- RUN/WAIT -> HALT on halt_valid_i for t. This wins over a redirect and an issue on the same cycle.

Selection:
- Eligible = RUN and not targeted by a redirect or halt this cycle.
- Search starts at rr_ptr, ascending modulo 4; the first eligible thread wins.
- After a grant, rr_ptr <= winner+1 (mod 4). rr_ptr is unchanged when nothing is granted.

Outputs and latency:
- Outputs are registered; the grant decided in cycle N appears in cycle N+1.
- On grant: fetch_valid_o<=1, fetch_tid_o<=t, fetch_pc_o<=pc[t], pc[t]<=pc[t]+PC_INC (wraps mod 2^PC_W).
- No eligible thread: fetch_valid_o<=0; tid/pc hold.

Stall:
- stall_i=1 holds all outputs, PCs, rr_ptr, states and gap counters.
- Redirect and halt are still applied during a stall.

Redirect:
- pc[t]<=redirect_pc_i. A thread in WAIT returns to RUN with its counter cleared.
- The thread is not granted in the redirect cycle; it is eligible the next cycle.
- Redirect to OFF/HALT threads is ignored.

Status outputs:
- thread_active_o and all_halted_o are registered from next-state.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- When defined:
  - Adds output issue_cnt_o (128 bits) holding four 32-bit per-thread grant counters (thread t at bits [32t+31:32t]).
  - Adds output idle_cnt_o (32 bits) counting non-stalled cycles with fetch_valid_o=0.
  - Counters are cleared by rst and by an accepted start_i; they saturate at 0xFFFFFFFF.
- When undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Round-robin: rst; start_i, thread_en_i=4'b1111, boot_pc_i=0x100, REISSUE_GAP=0 -> from the cycle after start, fetch_tid_o sequence 0,1,2,3,0, and fetch_pc_o 0x100,0x100,0x100,0x100,0x104.
- Sparse enable/gap: thread_en_i=4'b0101, REISSUE_GAP=1 -> tid 0,2,0,2 back-to-back; with only thread 0 enabled, fetch_valid_o alternates 1,0,1,0 and pc steps 0x100,0x104.
- Redirect: all threads running; redirect thread 2 to 0x400 in the cycle it would be granted -> thread 2 skipped that cycle; its next fetch_pc_o=0x400, then 0x404.
- Halt priority/all_halted: halt and redirect thread 1 on the same cycle -> thread 1 never fetches again. Halting all four -> fetch_valid_o=0 and all_halted_o=1 one cycle after the last halt.
- Stall: assert stall_i 3 cycles mid-run -> outputs frozen; after release, the sequence resumes at the next tid with no PC skipped or duplicated.
- Reset mid-run: rst during active fetch -> next cycle all outputs at reset values and all_halted_o=1; start_i restarts from boot_pc_i.
